// File: rtl/serial_add_ctrl_if.sv
// Handshake/operand bundle for serial_add_ctrl. The ovf member exists only
// when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, op_a, op_b, cin,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op_a, op_b, cin,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell sequenced over WIDTH cycles, LSB first.
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Single full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] fad(input logic a, input logic b, input logic c);
    fad = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       w_fad;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  assign w_fad  = fad(r_a_sh[0], r_b_sh[0], r_carry);
  assign w_s    = w_fad[0];
  assign w_c    = w_fad[1];
  assign w_last = (r_cnt == LAST);

  // Next-state decode; start is only honoured from IDLE or DONE.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next = ST_RUN;
          w_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_next = ST_DONE;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          w_next = ST_RUN;
          w_load = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
        w_load = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand shifters, carry, bit counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= {WIDTH{1'b0}};
      r_b_sh   <= {WIDTH{1'b0}};
      r_res_sh <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_sum    <= {WIDTH{1'b0}};
      r_cout   <= 1'b0;
    end else if (w_load) begin
      r_a_sh   <= bus.op_a;
      r_b_sh   <= bus.op_b;
      r_res_sh <= {WIDTH{1'b0}};
      r_carry  <= bus.cin;
      r_cnt    <= {CW{1'b0}};
    end else if (r_state == ST_RUN) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_res_sh <= {w_s, r_res_sh[WIDTH-1:1]};
      r_carry  <= w_c;
      if (w_last) begin
        // The final sum bit is folded in directly, not via r_res_sh.
        r_sum  <= {w_s, r_res_sh[WIDTH-1:1]};
        r_cout <= w_c;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  // Status flags registered from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_next == ST_RUN);
      r_done <= (w_next == ST_DONE);
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // Carry into the MSB is r_carry during the last RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last && !w_load) begin
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: timing-level reference model,
// per-cycle compare, directed cases with literal pins, randomized traffic.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted start schedules the result WIDTH edges later.
  int               m_rem;
  bit               m_done;
  logic [WIDTH-1:0] m_sum;
  logic             m_cout;
  logic             m_ovf;
  logic [WIDTH:0]   m_pend;
  logic             m_pend_ovf;

  function automatic logic signed_ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic c);
    int sa, sb, s;
    sa = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
    sb = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    s  = sa + sb + int'(c);
    return (s > (1 << (WIDTH - 1)) - 1) || (s < -(1 << (WIDTH - 1)));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem      <= 0;
      m_done     <= 1'b0;
      m_sum      <= '0;
      m_cout     <= 1'b0;
      m_ovf      <= 1'b0;
      m_pend     <= '0;
      m_pend_ovf <= 1'b0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_done <= 1'b1;
        m_sum  <= m_pend[WIDTH-1:0];
        m_cout <= m_pend[WIDTH];
        m_ovf  <= m_pend_ovf;
      end else begin
        m_done <= 1'b0;
      end
    end else if (bus.start) begin
      m_rem      <= WIDTH;
      m_done     <= 1'b0;
      m_pend     <= {1'b0, bus.op_a} + {1'b0, bus.op_b} + {{WIDTH{1'b0}}, bus.cin};
      m_pend_ovf <= signed_ovf(bus.op_a, bus.op_b, bus.cin);
    end else begin
      m_done <= 1'b0;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", 32'(bus.busy), 32'(m_rem != 0));
      chk("cyc_done", 32'(bus.done), 32'(m_done));
      chk("cyc_sum",  32'(bus.sum),  32'(m_sum));
      chk("cyc_cout", 32'(bus.cout), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
      chk("cyc_ovf",  32'(bus.ovf),  32'(m_ovf));
`endif
    end
  end

  // Pulse start for one edge, then count edges until done (bounded).
  task automatic issue_and_wait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic c, output int edges);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    edges = 1;
    while (!bus.done && edges < 40) begin
      @(posedge clk); #2;
      edges++;
    end
    if (!bus.done) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int edges;
    issue_and_wait(a, b, c, edges);
    chk({name, "_latency"}, 32'(edges), 32'(WIDTH + 1));
    chk({name, "_sum"},  32'(bus.sum),  32'(exp_sum));
    chk({name, "_cout"}, 32'(bus.cout), 32'(exp_cout));
    chk({name, "_model_sum"}, 32'(m_sum), 32'(exp_sum));
  endtask

  initial begin
    int edges;
    int busy_cycles;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum",  32'(bus.sum),  32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    @(posedge clk); #2;

    // Zero add, also counting busy cycles.
    bus.op_a = 8'h00; bus.op_b = 8'h00; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start   = 1'b0;
    busy_cycles = 0;
    edges       = 1;
    while (!bus.done && edges < 40) begin
      if (bus.busy) busy_cycles++;
      @(posedge clk); #2;
      edges++;
    end
    chk("zero_latency", 32'(edges), 32'd9);
    chk("zero_busy_cycles", 32'(busy_cycles), 32'd8);
    chk("zero_sum", 32'(bus.sum), 32'h00);
    chk("zero_cout", 32'(bus.cout), 32'd0);
    @(posedge clk); #2;

    run_op("ff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
    chk("ff01_ovf", 32'(bus.ovf), 32'd0);
`endif
    run_op("7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk("7f01_ovf", 32'(bus.ovf), 32'd1);
    chk("7f01_model_ovf", 32'(m_ovf), 32'd1);
`endif
    @(posedge clk); #2;
    run_op("a55a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    // Issued from the DONE cycle: back-to-back.
    run_op("3c0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
    @(posedge clk); #2;

    // start during RUN must be ignored.
    bus.op_a = 8'h11; bus.op_b = 8'h22; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    bus.op_a = 8'hEE; bus.op_b = 8'hEE; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    edges = 5;
    while (!bus.done && edges < 40) begin
      @(posedge clk); #2;
      edges++;
    end
    chk("ign_latency", 32'(edges), 32'd9);
    chk("ign_sum", 32'(bus.sum), 32'h33);
    repeat (12) begin
      @(posedge clk); #2;
      chk("ign_no_second_done", 32'(bus.done), 32'd0);
    end

    // Reset mid-run while the counter is 3.
    bus.op_a = 8'hC3; bus.op_b = 8'h81; bus.cin = 1'b1; bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_sum",  32'(bus.sum),  32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #2;
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_op("1234", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    // start held high with operands changing every cycle.
    for (int i = 0; i < 60; i++) begin
      bus.start = 1'b1;
      bus.op_a  = WIDTH'($urandom);
      bus.op_b  = WIDTH'($urandom);
      bus.cin   = 1'($urandom);
      @(posedge clk); #2;
    end
    bus.start = 1'b0;

    // Random traffic with sparse starts.
    for (int i = 0; i < 400; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.op_a  = WIDTH'($urandom);
      bus.op_b  = WIDTH'($urandom);
      bus.cin   = 1'($urandom);
      @(posedge clk); #2;
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
